alu_pipe: RTL and testbench
===========================

# alu_pipe

Parametrised, two-stage pipelined successor to the team's 32-bit combinational ALU: same eight-operation command set and flag semantics, generalised to any operand width. It adds valid/ready handshaking on both sides, back-pressure, and a sideband tag carried with each operation. It sits between an issue stage and a writeback/compare consumer and can stall without losing or duplicating operations.

## Interface
- WIDTH, 32, operand/result width in bits (≥ 2)
- TAG_W, 4, width of sideband tag carried alongside each operation (≥ 1)

- clk  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state on the clk edge where it is sampled high
- in_valid  in  1  operation presented
- in_ready  out  1  stage 1 can accept this cycle
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_cmd  in  3  0 ADD, 1 SUB, 2 XOR, 3 SLT, 4 AND, 5 NAND, 6 NOR, 7 OR
- in_tag  in  TAG_W  opaque tag, returned unchanged
- out_valid  out  1  result held
- out_ready  in  1  consumer accepts
- out_result  out  WIDTH  result
- out_carry  out  1  carry-out flag
- out_zero  out  1  result == 0
- out_ovf  out  1  signed overflow flag
- out_tag  out  TAG_W  tag of this result
- sticky_ovf  out  1  present only with ALU_PIPE_STICKY_EN
- sticky_clr  in  1  present only with ALU_PIPE_STICKY_EN

## Operation
- Stage 1 registers in_a, in_b, in_cmd, in_tag, and s1_valid on input transfer (in_valid && in_ready).
- Stage 2 computes from stage-1 registers and registers result, flags, tag, and s2_valid.
- Advance rules: s2 loads when s1_valid && (!s2_valid || out_ready); s1 loads when in_valid && in_ready; in_ready = !s1_valid || !s2_valid || out_ready.
- ADD: A+B mod 2^WIDTH; carry = carry out of MSB; ovf = A[MSB]==B[MSB] && R[MSB]!=A[MSB].
- SUB: A + ~B + 1; carry = carry out of MSB (1 = no borrow); ovf = A[MSB]!=B[MSB] && R[MSB]!=A[MSB].
- SLT: signed compare via SUB; result = {WIDTH-1 zeros, (diff[MSB] ^ sub_ovf)}; carry = ovf = 0.
- XOR/AND/NAND/NOR/OR: bitwise; carry = ovf = 0.
- zero = (result == 0) for every command, including SLT.
- Tag is carried bit-exact; results emerge in acceptance order.

## Timing
- Reset: s1_valid = s2_valid = 0, out_valid = 0, out_result = 0, out_carry = out_zero = out_ovf = 0, out_tag = 0, sticky_ovf = 0; in_ready = 1 the first cycle after reset.
- Latency: input transfer at edge N → out_valid high after edge N+1 (visible cycle N+1 to N+2), given no stall.
- Throughput: one op per cycle with out_ready held high.
- out_valid and all out_* held stable while out_valid && !out_ready.
- Full (both stages valid, out_ready low): in_ready = 0; in_a/in_b ignored.
- Same-cycle output transfer and input transfer on a full pipe: both complete; no bubble.
- Reset mid-operation drops all in-flight ops; no output transfer occurs on the reset edge.

## Configuration
- ALU_PIPE_STICKY_EN defined: sticky_ovf sets on any output transfer with out_ovf = 1 and stays set until sticky_clr sampled high or reset. Clear and set on the same edge → set wins.
- Undefined: sticky_ovf/sticky_clr ports and logic absent; all other behaviour identical.

## Test plan
- WIDTH=32, ADD 0x7FFFFFFF + 0x1 → result 0x80000000, ovf 1, carry 0, zero 0; 100 + 475 → 575, all flags 0.
- SUB 0x0FFF − 0x00FF → 0x0F00, carry 1; SUB 0x0 − 0xFFFF → 0xFFFF0001, carry 0, ovf 0.
- SLT 15422 vs 15421 → 0, zero 1; 15422 vs 15422 → 0, zero 1; 15422 vs 15423 → 1, zero 0; 0xFFFFFFFF vs 0x1 → 1; logic: XOR 0x0F0F^0xF0FF → 0xFFF0, NAND 0xFF00,0xFFF0 → 0xFFFF00FF, NOR 0x00FF,0x0FFF → 0xFFFFF000.
- Back-pressure: issue 5 tagged ops back-to-back, hold out_ready low 4 cycles → in_ready falls after 2 accepts, outputs stable; release → all 5 tags 0..4 emerge in order, none lost or repeated.
- WIDTH=8, TAG_W=2: ADD 0x7F + 0x01 → 0x80, ovf 1; ADD 0xFF + 0x01 → 0x00, carry 1, zero 1.
- ALU_PIPE_STICKY_EN: overflowing ADD then non-overflowing ADD → sticky_ovf 1 persists; sticky_clr pulse → 0; reset asserted with 2 ops in flight → out_valid 0 next cycle, sticky_ovf 0.

Source files
------------

// File: rtl/alu_pipe.sv
// ---------------------------------------------------------------------------
// alu_pipe
//
// Purpose:
//   A two-stage pipelined ALU. It supports the same eight commands and flags
//   as the team's older combinational 32-bit ALU, but the operand width is a
//   parameter. Both sides use valid/ready handshakes, so the block can stall
//   for back-pressure without losing or duplicating an operation. Each
//   operation carries an opaque tag that is returned unchanged with its
//   result. Results leave in the same order the operations were accepted.
//
//   Stage 1 captures the operands, command and tag.
//   Stage 2 computes the result and flags from the stage-1 registers and
//   holds them until the consumer takes them.
//
// Parameters:
//   WIDTH  operand/result width in bits (>= 2)
//   TAG_W  sideband tag width in bits (>= 1)
//
// Ports:
//   clk         sole clock, rising edge
//   reset       synchronous, active-high; drops every in-flight operation
//   in_valid    issue side presents an operation
//   in_ready    stage 1 can accept an operation this cycle
//   in_a/in_b   operands A and B
//   in_cmd      0 ADD, 1 SUB, 2 XOR, 3 SLT, 4 AND, 5 NAND, 6 NOR, 7 OR
//   in_tag      opaque tag
//   out_valid   a result is held on the out_* ports
//   out_ready   consumer accepts the held result
//   out_result  result
//   out_carry   carry out of the MSB (ADD/SUB only; 1 = no borrow for SUB)
//   out_zero    result == 0
//   out_ovf     signed overflow (ADD/SUB only)
//   out_tag     tag of the held result
//
// Optional feature (compile-time macro ALU_PIPE_STICKY_EN):
//   sticky_ovf  sets whenever a result with out_ovf = 1 is transferred, and
//               stays set until sticky_clr is sampled high or reset occurs
//   sticky_clr  clears sticky_ovf; a set on the same edge takes priority
//   When the macro is undefined, these ports and their logic are absent.
// ---------------------------------------------------------------------------
module alu_pipe #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_cmd,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry,
    output logic             out_zero,
    output logic             out_ovf,
`ifdef ALU_PIPE_STICKY_EN
    output logic [TAG_W-1:0] out_tag,
    output logic             sticky_ovf,
    input  logic             sticky_clr
`else
    output logic [TAG_W-1:0] out_tag
`endif
);

    localparam int MSB = WIDTH - 1;

    // Command encoding shared with the issue stage.
    typedef enum logic [2:0] {
        CMD_ADD  = 3'd0,
        CMD_SUB  = 3'd1,
        CMD_XOR  = 3'd2,
        CMD_SLT  = 3'd3,
        CMD_AND  = 3'd4,
        CMD_NAND = 3'd5,
        CMD_NOR  = 3'd6,
        CMD_OR   = 3'd7
    } cmdE;

    // Stage 1 registers and their next-state values.
    logic             s1Valid_q, s1Valid_d;
    logic [WIDTH-1:0] s1A_q,     s1A_d;
    logic [WIDTH-1:0] s1B_q,     s1B_d;
    cmdE              s1Cmd_q,   s1Cmd_d;
    logic [TAG_W-1:0] s1Tag_q,   s1Tag_d;

    // Stage 2 (output) registers and their next-state values.
    logic             s2Valid_q,  s2Valid_d;
    logic [WIDTH-1:0] s2Result_q, s2Result_d;
    logic             s2Carry_q,  s2Carry_d;
    logic             s2Zero_q,   s2Zero_d;
    logic             s2Ovf_q,    s2Ovf_d;
    logic [TAG_W-1:0] s2Tag_q,    s2Tag_d;

    // Handshake events.
    logic s1Load;
    logic s2Load;
    logic outXfer;

    // Combinational ALU results, computed from the stage-1 registers.
    logic [WIDTH:0]   addSum;
    logic [WIDTH:0]   subSum;
    logic             addOvf;
    logic             subOvf;
    logic             sltBit;
    logic [WIDTH-1:0] aluResult;
    logic             aluCarry;
    logic             aluOvf;

    // Pipeline control.
    // Stage 2 can take a new operation when it is empty, or when its current
    // result is leaving this cycle. Stage 1 can accept when it is empty, or
    // when its contents are moving into stage 2. The second condition is
    // written out in terms of the stage-2 state so that in_ready does not
    // depend on in_valid.
    always_comb begin
        in_ready = !s1Valid_q || !s2Valid_q || out_ready;
        s1Load   = in_valid && in_ready;
        s2Load   = s1Valid_q && (!s2Valid_q || out_ready);
        outXfer  = s2Valid_q && out_ready;
    end

    // Datapath.
    // ADD and SUB each have their own adder, so the carry out of the extra
    // top bit is directly the MSB carry. SUB computes A + ~B + 1, so a carry
    // of 1 means "no borrow". SLT reuses the SUB difference: the sign of the
    // difference, corrected by the signed-overflow bit, gives the signed
    // less-than result.
    always_comb begin
        addSum = {1'b0, s1A_q} + {1'b0, s1B_q};
        subSum = {1'b0, s1A_q} + {1'b0, ~s1B_q} + {{WIDTH{1'b0}}, 1'b1};

        addOvf = (s1A_q[MSB] == s1B_q[MSB]) && (addSum[MSB] != s1A_q[MSB]);
        subOvf = (s1A_q[MSB] != s1B_q[MSB]) && (subSum[MSB] != s1A_q[MSB]);
        sltBit = subSum[MSB] ^ subOvf;

        aluResult = '0;
        aluCarry  = 1'b0;
        aluOvf    = 1'b0;

        case (s1Cmd_q)
            CMD_ADD: begin
                aluResult = addSum[WIDTH-1:0];
                aluCarry  = addSum[WIDTH];
                aluOvf    = addOvf;
            end
            CMD_SUB: begin
                aluResult = subSum[WIDTH-1:0];
                aluCarry  = subSum[WIDTH];
                aluOvf    = subOvf;
            end
            CMD_SLT:  aluResult = {{(WIDTH-1){1'b0}}, sltBit};
            CMD_XOR:  aluResult = s1A_q ^ s1B_q;
            CMD_AND:  aluResult = s1A_q & s1B_q;
            CMD_NAND: aluResult = ~(s1A_q & s1B_q);
            CMD_NOR:  aluResult = ~(s1A_q | s1B_q);
            CMD_OR:   aluResult = s1A_q | s1B_q;
            default:  aluResult = '0;
        endcase
    end

    // Stage 1 next state.
    // The operand registers change only on an input transfer. This keeps
    // them stable while the operation waits for stage 2 to free up. The
    // valid flag clears when the operation moves on and nothing new arrives
    // in the same cycle.
    always_comb begin
        s1Valid_d = s1Valid_q;
        s1A_d     = s1A_q;
        s1B_d     = s1B_q;
        s1Cmd_d   = s1Cmd_q;
        s1Tag_d   = s1Tag_q;

        if (s1Load) begin
            s1Valid_d = 1'b1;
            s1A_d     = in_a;
            s1B_d     = in_b;
            s1Cmd_d   = cmdE'(in_cmd);
            s1Tag_d   = in_tag;
        end else if (s2Load) begin
            s1Valid_d = 1'b0;
        end
    end

    // Stage 2 next state.
    // The result and flags are captured only when stage 2 loads. This is
    // what holds the out_* ports stable while the consumer stalls. The valid
    // flag drops after a transfer unless a new result replaces it on the
    // same edge.
    always_comb begin
        s2Valid_d  = s2Valid_q;
        s2Result_d = s2Result_q;
        s2Carry_d  = s2Carry_q;
        s2Zero_d   = s2Zero_q;
        s2Ovf_d    = s2Ovf_q;
        s2Tag_d    = s2Tag_q;

        if (s2Load) begin
            s2Valid_d  = 1'b1;
            s2Result_d = aluResult;
            s2Carry_d  = aluCarry;
            s2Zero_d   = (aluResult == '0);
            s2Ovf_d    = aluOvf;
            s2Tag_d    = s1Tag_q;
        end else if (outXfer) begin
            s2Valid_d = 1'b0;
        end
    end

    // Pipeline registers. Reset clears both the payloads and the valid
    // flags, so the outputs read as zero straight after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1Valid_q  <= 1'b0;
            s1A_q      <= '0;
            s1B_q      <= '0;
            s1Cmd_q    <= CMD_ADD;
            s1Tag_q    <= '0;
            s2Valid_q  <= 1'b0;
            s2Result_q <= '0;
            s2Carry_q  <= 1'b0;
            s2Zero_q   <= 1'b0;
            s2Ovf_q    <= 1'b0;
            s2Tag_q    <= '0;
        end else begin
            s1Valid_q  <= s1Valid_d;
            s1A_q      <= s1A_d;
            s1B_q      <= s1B_d;
            s1Cmd_q    <= s1Cmd_d;
            s1Tag_q    <= s1Tag_d;
            s2Valid_q  <= s2Valid_d;
            s2Result_q <= s2Result_d;
            s2Carry_q  <= s2Carry_d;
            s2Zero_q   <= s2Zero_d;
            s2Ovf_q    <= s2Ovf_d;
            s2Tag_q    <= s2Tag_d;
        end
    end

    // Output ports are driven directly from the stage-2 registers.
    always_comb begin
        out_valid  = s2Valid_q;
        out_result = s2Result_q;
        out_carry  = s2Carry_q;
        out_zero   = s2Zero_q;
        out_ovf    = s2Ovf_q;
        out_tag    = s2Tag_q;
    end

`ifdef ALU_PIPE_STICKY_EN
    logic stickyOvf_q, stickyOvf_d;

    // Sticky overflow.
    // It sets only when an overflowing result actually leaves the pipe, not
    // while the result is merely held. A set on the same edge as a clear
    // wins, so an overflow cannot slip past a clear pulse unnoticed.
    always_comb begin
        stickyOvf_d = stickyOvf_q;
        if (sticky_clr) begin
            stickyOvf_d = 1'b0;
        end
        if (outXfer && s2Ovf_q) begin
            stickyOvf_d = 1'b1;
        end
    end

    // Sticky overflow register; reset clears it like the rest of the pipe.
    always_ff @(posedge clk) begin
        if (reset) begin
            stickyOvf_q <= 1'b0;
        end else begin
            stickyOvf_q <= stickyOvf_d;
        end
    end

    assign sticky_ovf = stickyOvf_q;
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// ---------------------------------------------------------------------------
// tb_alu_pipe
//
// Directed testbench for alu_pipe. It uses one 32-bit/4-bit-tag instance and
// one 8-bit/2-bit-tag instance. Inputs are driven on the falling clock edge
// and outputs are sampled on the falling edge, away from the active edge.
// The sticky-overflow scenarios are built only when ALU_PIPE_STICKY_EN is
// defined.
// ---------------------------------------------------------------------------
module tb_alu_pipe;

    logic        clk;
    logic        reset;

    // Signals for the 32-bit instance.
    logic        inValid;
    logic        inReady;
    logic [31:0] inA;
    logic [31:0] inB;
    logic [2:0]  inCmd;
    logic [3:0]  inTag;
    logic        outValid;
    logic        outReady;
    logic [31:0] outResult;
    logic        outCarry;
    logic        outZero;
    logic        outOvf;
    logic [3:0]  outTag;

    // Signals for the 8-bit instance.
    logic        in8Valid;
    logic        in8Ready;
    logic [7:0]  in8A;
    logic [7:0]  in8B;
    logic [2:0]  in8Cmd;
    logic [1:0]  in8Tag;
    logic        out8Valid;
    logic        out8Ready;
    logic [7:0]  out8Result;
    logic        out8Carry;
    logic        out8Zero;
    logic        out8Ovf;
    logic [1:0]  out8Tag;

`ifdef ALU_PIPE_STICKY_EN
    logic        stickyOvf;
    logic        stickyClr;
    logic        sticky8Ovf;
    logic        sticky8Clr;
`endif

    int assertCount = 0;
    int failCount   = 0;

    alu_pipe #(.WIDTH(32), .TAG_W(4)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (inValid),
        .in_ready   (inReady),
        .in_a       (inA),
        .in_b       (inB),
        .in_cmd     (inCmd),
        .in_tag     (inTag),
        .out_valid  (outValid),
        .out_ready  (outReady),
        .out_result (outResult),
        .out_carry  (outCarry),
        .out_zero   (outZero),
        .out_ovf    (outOvf),
`ifdef ALU_PIPE_STICKY_EN
        .out_tag    (outTag),
        .sticky_ovf (stickyOvf),
        .sticky_clr (stickyClr)
`else
        .out_tag    (outTag)
`endif
    );

    alu_pipe #(.WIDTH(8), .TAG_W(2)) u_dut8 (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in8Valid),
        .in_ready   (in8Ready),
        .in_a       (in8A),
        .in_b       (in8B),
        .in_cmd     (in8Cmd),
        .in_tag     (in8Tag),
        .out_valid  (out8Valid),
        .out_ready  (out8Ready),
        .out_result (out8Result),
        .out_carry  (out8Carry),
        .out_zero   (out8Zero),
        .out_ovf    (out8Ovf),
`ifdef ALU_PIPE_STICKY_EN
        .out_tag    (out8Tag),
        .sticky_ovf (sticky8Ovf),
        .sticky_clr (sticky8Clr)
`else
        .out_tag    (out8Tag)
`endif
    );

    // Free-running clock with a 10-time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one operation to the 32-bit instance with out_ready held high.
    // The task returns at the falling edge where the result is first
    // visible.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 input logic [2:0] cmd, input logic [3:0] tag);
        @(negedge clk);
        inValid = 1'b1;
        inA     = a;
        inB     = b;
        inCmd   = cmd;
        inTag   = tag;
        @(negedge clk);
        inValid = 1'b0;
        @(negedge clk);
    endtask

    // Same as applyStimulus, but for the 8-bit instance.
    task automatic applyStimulus8(input logic [7:0] a, input logic [7:0] b,
                                  input logic [2:0] cmd, input logic [1:0] tag);
        @(negedge clk);
        in8Valid = 1'b1;
        in8A     = a;
        in8B     = b;
        in8Cmd   = cmd;
        in8Tag   = tag;
        @(negedge clk);
        in8Valid = 1'b0;
        @(negedge clk);
    endtask

    // Reset state: all outputs zero, the pipe ready to accept, and nothing
    // captured while reset is held, even though in_valid is high.
    task automatic test_reset();
        logic [40:0] got;
        reset    = 1'b1;
        inValid  = 1'b1;
        inA      = 32'hDEAD_BEEF;
        inB      = 32'h1234_5678;
        inCmd    = 3'd1;
        inTag    = 4'hA;
        outReady = 1'b1;
        in8Valid = 1'b0;
        in8A     = 8'h0;
        in8B     = 8'h0;
        in8Cmd   = 3'd0;
        in8Tag   = 2'd0;
        out8Ready = 1'b1;
`ifdef ALU_PIPE_STICKY_EN
        stickyClr  = 1'b0;
        sticky8Clr = 1'b0;
`endif
        repeat (3) @(negedge clk);
        got = {outValid, outResult, outCarry, outZero, outOvf, outTag, inReady};
        assertCount++;
        if (got !== {40'h0, 1'b1}) begin
            failCount++;
            $display("[TB] FAIL reset_state: got %h expected %h", got, {40'h0, 1'b1});
        end
        assertCount++;
        if ({out8Valid, out8Result, out8Tag, in8Ready} !== 12'h001) begin
            failCount++;
            $display("[TB] FAIL reset_state8: got %h expected %h",
                     {out8Valid, out8Result, out8Tag, in8Ready}, 12'h001);
        end
`ifdef ALU_PIPE_STICKY_EN
        assertCount++;
        if (stickyOvf !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL reset_sticky: got %b expected 0", stickyOvf);
        end
`endif
        reset   = 1'b0;
        inValid = 1'b0;
        repeat (2) @(negedge clk);
        assertCount++;
        if ({outValid, inReady} !== 2'b01) begin
            failCount++;
            $display("[TB] FAIL post_reset_idle: got %b expected 01", {outValid, inReady});
        end
    endtask

    // ADD, including signed overflow, carry out and a zero result.
    task automatic test_add();
        logic [31:0] va [4] = '{32'h7FFF_FFFF, 32'd100, 32'hFFFF_FFFF, 32'h8000_0000};
        logic [31:0] vb [4] = '{32'h0000_0001, 32'd475, 32'h0000_0001, 32'h8000_0000};
        logic [34:0] ve [4] = '{{32'h8000_0000, 3'b001}, {32'd575, 3'b000},
                                {32'h0, 3'b110}, {32'h0, 3'b111}};
        logic [39:0] got, exp;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(va[i], vb[i], 3'd0, 4'(i + 1));
            got = {outValid, outResult, outCarry, outZero, outOvf, outTag};
            exp = {1'b1, ve[i], 4'(i + 1)};
            assertCount++;
            if (got !== exp) begin
                failCount++;
                $display("[TB] FAIL add[%0d]: got %h expected %h", i, got, exp);
            end
        end
    endtask

    // SUB: carry 1 means no borrow; includes overflow and zero cases.
    task automatic test_sub();
        logic [31:0] va [4] = '{32'h0000_0FFF, 32'h0, 32'h8000_0000, 32'd5};
        logic [31:0] vb [4] = '{32'h0000_00FF, 32'h0000_FFFF, 32'h1, 32'd5};
        logic [34:0] ve [4] = '{{32'h0000_0F00, 3'b100}, {32'hFFFF_0001, 3'b000},
                                {32'h7FFF_FFFF, 3'b101}, {32'h0, 3'b110}};
        logic [39:0] got, exp;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(va[i], vb[i], 3'd1, 4'(i + 5));
            got = {outValid, outResult, outCarry, outZero, outOvf, outTag};
            exp = {1'b1, ve[i], 4'(i + 5)};
            assertCount++;
            if (got !== exp) begin
                failCount++;
                $display("[TB] FAIL sub[%0d]: got %h expected %h", i, got, exp);
            end
        end
    endtask

    // SLT: signed compare, including the most-negative versus most-positive
    // cases where the subtraction overflows.
    task automatic test_slt();
        logic [31:0] va [6] = '{32'd15422, 32'd15422, 32'd15422, 32'hFFFF_FFFF,
                                32'h8000_0000, 32'h7FFF_FFFF};
        logic [31:0] vb [6] = '{32'd15421, 32'd15422, 32'd15423, 32'h1,
                                32'h7FFF_FFFF, 32'h8000_0000};
        logic [34:0] ve [6] = '{{32'd0, 3'b010}, {32'd0, 3'b010}, {32'd1, 3'b000},
                                {32'd1, 3'b000}, {32'd1, 3'b000}, {32'd0, 3'b010}};
        logic [39:0] got, exp;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(va[i], vb[i], 3'd3, 4'(i + 9));
            got = {outValid, outResult, outCarry, outZero, outOvf, outTag};
            exp = {1'b1, ve[i], 4'(i + 9)};
            assertCount++;
            if (got !== exp) begin
                failCount++;
                $display("[TB] FAIL slt[%0d]: got %h expected %h", i, got, exp);
            end
        end
    endtask

    // Bitwise commands: carry and ovf must stay 0 even with operands that
    // would carry under ADD.
    task automatic test_logic();
        logic [2:0]  vc [8] = '{3'd2, 3'd5, 3'd6, 3'd4, 3'd7, 3'd2, 3'd4, 3'd4};
        logic [31:0] va [8] = '{32'h0F0F, 32'hFF00, 32'h00FF, 32'hFF00, 32'hF000,
                                32'h1234, 32'hA5A5_A5A5, 32'hFFFF_FFFF};
        logic [31:0] vb [8] = '{32'hF0FF, 32'hFFF0, 32'h0FFF, 32'h0FF0, 32'h000F,
                                32'h1234, 32'h5A5A_5A5A, 32'hFFFF_FFFF};
        logic [34:0] ve [8] = '{{32'h0000_FFF0, 3'b000}, {32'hFFFF_00FF, 3'b000},
                                {32'hFFFF_F000, 3'b000}, {32'h0000_0F00, 3'b000},
                                {32'h0000_F00F, 3'b000}, {32'h0, 3'b010},
                                {32'h0, 3'b010}, {32'hFFFF_FFFF, 3'b000}};
        logic [39:0] got, exp;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(va[i], vb[i], vc[i], 4'(i));
            got = {outValid, outResult, outCarry, outZero, outOvf, outTag};
            exp = {1'b1, ve[i], 4'(i)};
            assertCount++;
            if (got !== exp) begin
                failCount++;
                $display("[TB] FAIL logic[%0d]: got %h expected %h", i, got, exp);
            end
        end
    endtask

    // Throughput: six operations on consecutive cycles with out_ready held
    // high. Results must appear on consecutive cycles with no bubble.
    task automatic test_back_to_back();
        logic [36:0] got, exp;
        outReady = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c < 6) begin
                inValid = 1'b1;
                inA     = 32'(c);
                inB     = 32'd100;
                inCmd   = 3'd0;
                inTag   = 4'(c + 3);
            end else begin
                inValid = 1'b0;
            end
            #1;
            if (c < 6) begin
                assertCount++;
                if (inReady !== 1'b1) begin
                    failCount++;
                    $display("[TB] FAIL b2b_in_ready[%0d]: got %b expected 1", c, inReady);
                end
            end
            if (c >= 2) begin
                got = {outValid, outResult, outTag};
                exp = {1'b1, 32'(c - 2 + 100), 4'(c + 1)};
                assertCount++;
                if (got !== exp) begin
                    failCount++;
                    $display("[TB] FAIL b2b_out[%0d]: got %h expected %h", c, got, exp);
                end
            end
        end
    endtask

    // Back-pressure: five tagged operations are offered while out_ready is
    // low for four cycles. Only two are accepted, and the held output must
    // stay stable. After release, tags 0..4 must leave in order exactly once.
    task automatic test_backpressure();
        int nextIssue  = 0;
        int nextExpect = 0;
        int cyc        = 0;
        logic [37:0] got, exp;
        while (nextExpect < 5 && cyc < 40) begin
            @(negedge clk);
            outReady = (cyc >= 4);
            if (nextIssue < 5) begin
                inValid = 1'b1;
                inA     = 32'(nextIssue);
                inB     = 32'd10;
                inCmd   = 3'd0;
                inTag   = 4'(nextIssue);
            end else begin
                inValid = 1'b0;
            end
            #1;
            if (cyc == 2 || cyc == 3) begin
                got = {outValid, outResult, outTag, inReady};
                exp = {1'b1, 32'd10, 4'd0, 1'b0};
                assertCount++;
                if (got !== exp) begin
                    failCount++;
                    $display("[TB] FAIL bp_stall[%0d]: got %h expected %h", cyc, got, exp);
                end
            end
            if (cyc == 3) begin
                assertCount++;
                if (nextIssue != 2) begin
                    failCount++;
                    $display("[TB] FAIL bp_accepts: got %0d expected 2", nextIssue);
                end
            end
            if (outValid && outReady) begin
                got = {1'b0, outResult, outTag, 1'b0};
                exp = {1'b0, 32'(nextExpect + 10), 4'(nextExpect), 1'b0};
                assertCount++;
                if (got !== exp) begin
                    failCount++;
                    $display("[TB] FAIL bp_order[%0d]: got %h expected %h", nextExpect, got, exp);
                end
                nextExpect++;
            end
            if (inValid && inReady) begin
                nextIssue++;
            end
            cyc++;
        end
        @(negedge clk);
        inValid  = 1'b0;
        outReady = 1'b1;
        assertCount++;
        if (nextExpect != 5) begin
            failCount++;
            $display("[TB] FAIL bp_count: got %0d expected 5", nextExpect);
        end
        assertCount++;
        if (outValid !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL bp_drained: got %b expected 0", outValid);
        end
    endtask

    // Narrow instance (WIDTH=8, TAG_W=2): overflow, wrap to zero with
    // carry, SUB overflow, and signed SLT.
    task automatic test_width8();
        logic [7:0]  va [4] = '{8'h7F, 8'hFF, 8'h80, 8'h80};
        logic [7:0]  vb [4] = '{8'h01, 8'h01, 8'h01, 8'h01};
        logic [2:0]  vc [4] = '{3'd0, 3'd0, 3'd1, 3'd3};
        logic [10:0] ve [4] = '{{8'h80, 3'b001}, {8'h00, 3'b110},
                                {8'h7F, 3'b101}, {8'h01, 3'b000}};
        logic [13:0] got, exp;
        for (int i = 0; i < 4; i++) begin
            applyStimulus8(va[i], vb[i], vc[i], 2'(i));
            got = {out8Valid, out8Result, out8Carry, out8Zero, out8Ovf, out8Tag};
            exp = {1'b1, ve[i], 2'(i)};
            assertCount++;
            if (got !== exp) begin
                failCount++;
                $display("[TB] FAIL width8[%0d]: got %h expected %h", i, got, exp);
            end
        end
    endtask

`ifdef ALU_PIPE_STICKY_EN
    // Sticky overflow: sets on an overflowing transfer, persists through a
    // clean one, clears on sticky_clr, and a set wins over a same-edge clear.
    task automatic test_sticky();
        outReady  = 1'b1;
        stickyClr = 1'b0;
        applyStimulus(32'h7FFF_FFFF, 32'h1, 3'd0, 4'd1);
        @(negedge clk);
        assertCount++;
        if (stickyOvf !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL sticky_set: got %b expected 1", stickyOvf);
        end
        applyStimulus(32'd1, 32'd1, 3'd0, 4'd2);
        @(negedge clk);
        assertCount++;
        if (stickyOvf !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL sticky_hold: got %b expected 1", stickyOvf);
        end
        stickyClr = 1'b1;
        @(negedge clk);
        stickyClr = 1'b0;
        assertCount++;
        if (stickyOvf !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL sticky_clr: got %b expected 0", stickyOvf);
        end
        applyStimulus(32'h8000_0000, 32'h8000_0000, 3'd0, 4'd3);
        stickyClr = 1'b1;
        @(negedge clk);
        stickyClr = 1'b0;
        assertCount++;
        if (stickyOvf !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL sticky_set_wins: got %b expected 1", stickyOvf);
        end
    endtask
`endif

    // Reset with two operations in flight and the consumer stalled. Both
    // operations must be dropped and all outputs must return to zero.
    task automatic test_reset_midflight();
        logic [40:0] got;
        outReady = 1'b0;
        @(negedge clk);
        inValid = 1'b1;
        inA     = 32'h7FFF_FFFF;
        inB     = 32'h1;
        inCmd   = 3'd0;
        inTag   = 4'd7;
        @(negedge clk);
        inTag   = 4'd8;
        @(negedge clk);
        inValid = 1'b0;
        #1;
        assertCount++;
        if ({outValid, inReady} !== 2'b10) begin
            failCount++;
            $display("[TB] FAIL midflight_full: got %b expected 10", {outValid, inReady});
        end
        reset    = 1'b1;
        outReady = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        got = {outValid, outResult, outCarry, outZero, outOvf, outTag, inReady};
        assertCount++;
        if (got !== {40'h0, 1'b1}) begin
            failCount++;
            $display("[TB] FAIL midflight_reset: got %h expected %h", got, {40'h0, 1'b1});
        end
`ifdef ALU_PIPE_STICKY_EN
        assertCount++;
        if (stickyOvf !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL midflight_sticky: got %b expected 0", stickyOvf);
        end
`endif
        repeat (2) @(negedge clk);
        assertCount++;
        if (outValid !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL midflight_dropped: got %b expected 0", outValid);
        end
    endtask

    // Run the scenarios in sequence, then print the summary line.
    initial begin
        test_reset();
        test_add();
        test_sub();
        test_slt();
        test_logic();
        test_back_to_back();
        test_backpressure();
        test_width8();
`ifdef ALU_PIPE_STICKY_EN
        test_sticky();
`endif
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
